poseidon_arbiter: RTL
=====================

# poseidon_arbiter

Shares one Poseidon hash core between `NUM_REQ` requester streams. Each requester sends 9-beat frames of 255-bit field elements with `last` on beat 8. Frames are granted whole, round-robin, onto the core input stream. An in-order tag FIFO routes each core result back to the requester that issued the frame. The block sits between the requester stream ports and the `PoseidonTopLevel` `io_input_*` / `io_output_*` ports.

## Interface
- `NUM_REQ`, 4: requester count, 2..8.
- `DATA_W`, 255: field element width.
- `TAG_DEPTH`, 8: max frames in flight in the core; power of 2.
- `clk` input 1: clock, rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `req_valid` input NUM_REQ: per-requester input valid.
- `req_ready` output NUM_REQ: per-requester input ready.
- `req_last` input NUM_REQ: per-requester last beat of frame.
- `req_payload` input NUM_REQ*DATA_W: requester i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].
- `core_in_valid` / `core_in_ready` / `core_in_last` output/input/output 1: core input handshake.
- `core_in_payload` output DATA_W: core input data.
- `core_out_valid` / `core_out_ready` / `core_out_last` input/output/input 1: core result handshake.
- `core_out_payload` input DATA_W: core result data.
- `rsp_valid` output NUM_REQ: one-hot result valid to the owning requester.
- `rsp_ready` input NUM_REQ: per-requester result ready.
- `rsp_last` output 1: copy of `core_out_last`.
- `rsp_payload` output DATA_W: shared result bus, copy of `core_out_payload`.
- `inflight` output $clog2(TAG_DEPTH)+1: tag FIFO occupancy.
- `err` output 1: sticky protocol error.

## Operation
- Input FSM has two states: IDLE and SEND. Registers: `grant` (index), `rr_ptr`, state.
- IDLE → SEND when any `req_valid` is 1 and the tag FIFO is not full.
  - Winner: the first valid index at or after `rr_ptr`, searching cyclically.
  - On the same edge: `grant` ← winner, `rr_ptr` ← winner+1 mod NUM_REQ, winner pushed into the tag FIFO.
  - When the FIFO is full, arbitration stalls even if a pop occurs in the same cycle.
- SEND: `core_in_valid`, `core_in_last` and `core_in_payload` are driven from requester `grant`, combinationally.
  - `req_ready[grant]` = `core_in_ready`. All other `req_ready` bits are 0.
- SEND → IDLE on a core input handshake with `core_in_last`=1.
- Frame length is not checked. `last` alone ends the grant.
- In IDLE, `core_in_valid`=0 and `req_ready`=0.
- Output path, FIFO non-empty, head tag h:
  - `rsp_valid[h]` = `core_out_valid`.
  - `core_out_ready` = `rsp_ready[h]`.
  - The tag pops on an output handshake with `core_out_last`=1.
- Output path, FIFO empty:
  - `core_out_ready`=0 and `rsp_valid`=0.
  - If `core_out_valid` is 1, `err` is set. It clears only on reset.
- Push and pop in the same cycle: occupancy is unchanged and pointers wrap mod TAG_DEPTH.
- `inflight` counts frames granted but whose result has not yet been consumed.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `rr_ptr`=0.
  - FIFO empty, `inflight`=0, `err`=0.
  - All `req_ready`=0, `core_in_valid`=0, `rsp_valid`=0, `core_out_ready`=0.
- Reset mid-frame or with results in flight discards every tag. Results arriving after reset with the FIFO empty set `err`.
- Arbitration costs one bubble cycle per frame: one IDLE cycle between the last beat of a frame and beat 0 of the next.
- Data paths are combinational in both directions, with zero added latency. A 9-beat frame with the core always ready occupies 10 cycles including arbitration.
- `core_in_valid` must not drop mid-frame unless `req_valid[grant]` drops. Requesters follow the valid/ready rules, so it never does.

## Configuration
- `POSEIDON_ARB_FIXED_PRIO_EN` defined: the winner is the lowest valid index; `rr_ptr` is unused and held at 0.
- `POSEIDON_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- Single requester 0 sends one 9-beat frame, core ready → beats 0-8 reach the core on cycles 1-9 after arbitration; the result returns with `rsp_valid`=4'b0001 and `inflight` goes 1→0.
- Requesters 0-3 all valid continuously, default build → grant order 0,1,2,3,0; each result is routed to its issuing requester in grant order.
- Same stimulus with `POSEIDON_ARB_FIXED_PRIO_EN` → requester 0 wins every arbitration while it stays valid.
- TAG_DEPTH=8, core output held not-ready while 8 frames are sent → `inflight`=8; the 9th frame gets no grant until one result is consumed.
- `rsp_ready` of the owning requester low for 5 cycles → `core_out_ready`=0 for those cycles, the result is held, and no tag pops.
- `core_out_valid`=1 with the FIFO empty → `err`=1 and stays 1; assert `resetn`=0 for one cycle → `err`=0 and all outputs at reset values.

Source files
------------

// File: rtl/poseidon_arbiter.sv
// Shares one Poseidon hash core between NUM_REQ requester streams: whole frames are granted
// round-robin and an in-order tag FIFO steers each result back. Define POSEIDON_ARB_FIXED_PRIO_EN for fixed priority.
module poseidon_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 255,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  req_payload,
    output logic                       core_in_valid,
    input  logic                       core_in_ready,
    output logic                       core_in_last,
    output logic [DATA_W-1:0]          core_in_payload,
    input  logic                       core_out_valid,
    output logic                       core_out_ready,
    input  logic                       core_out_last,
    input  logic [DATA_W-1:0]          core_out_payload,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic                       rsp_last,
    output logic [DATA_W-1:0]          rsp_payload,
    output logic [$clog2(TAG_DEPTH):0] inflight,
    output logic                       err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic [IDX_W-1:0] winner, head;
    logic [IDX_W-1:0] cand;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign head       = tag_mem_q[rd_ptr_q];

    // Iterating from the far end lets the nearest valid candidate overwrite the others.
    always_comb begin
        winner = '0;
        cand   = '0;
`ifdef POSEIDON_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req_valid[cand]) winner = cand;
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) winner = cand;
        end
`endif
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|req_valid) && !fifo_full) begin
                    state_d = S_SEND;
                    grant_d = winner;
                    push    = 1'b1;
`ifdef POSEIDON_ARB_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
                end
            end
            S_SEND: begin
                if (core_in_valid && core_in_ready && core_in_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = '0;
        core_in_valid   = 1'b0;
        core_in_last    = 1'b0;
        core_in_payload = req_payload[grant_q*DATA_W +: DATA_W];
        if (state_q == S_SEND) begin
            core_in_valid      = req_valid[grant_q];
            core_in_last       = req_last[grant_q];
            req_ready[grant_q] = core_in_ready;
        end
    end

    // Results are routed to the oldest outstanding tag; nothing is accepted with no tag pending.
    always_comb begin
        rsp_valid      = '0;
        core_out_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head] = core_out_valid;
            core_out_ready  = rsp_ready[head];
        end
    end

    assign pop         = core_out_valid && core_out_ready && core_out_last;
    assign rsp_last    = core_out_last;
    assign rsp_payload = core_out_payload;
    assign inflight    = count_q;
    assign err         = err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (fifo_empty && core_out_valid) err_q <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= winner;
    end

endmodule
